// File: rtl/bsg_mem_1r1w_sync_fifo_ctrl.sv
// FIFO controller that sequences an external 1R1W synchronous-read RAM and hides its read latency
// behind a 2-entry head/skid output buffer. Optional checker: BSG_MEM_1R1W_SYNC_FIFO_CTRL_CHECK_EN.
module bsg_mem_1r1w_sync_fifo_ctrl #(
    parameter int width_p = 8,
    parameter int els_p   = 4,
    localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int cnt_width_lp  = $clog2(els_p + 3)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    input  logic [width_p-1:0]       data_i,
    output logic                     ready_o,
    output logic                     v_o,
    output logic [width_p-1:0]       data_o,
    input  logic                     yumi_i,
    output logic [cnt_width_lp-1:0]  count_o,
    output logic                     mem_w_v_o,
    output logic [addr_width_lp-1:0] mem_w_addr_o,
    output logic [width_p-1:0]       mem_w_data_o,
    output logic                     mem_r_v_o,
    output logic [addr_width_lp-1:0] mem_r_addr_o,
    input  logic [width_p-1:0]       mem_r_data_i
);

    localparam logic [addr_width_lp-1:0] last_ptr_lp = addr_width_lp'(els_p - 1);
    localparam logic [cnt_width_lp-1:0]  els_cnt_lp  = cnt_width_lp'(els_p);

    logic [addr_width_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cnt_width_lp-1:0]  ram_cnt_q, ram_cnt_d, count_q, count_d;
    logic                     rd_inflight_q, rd_inflight_d;
    logic                     head_v_q, head_v_d, skid_v_q, skid_v_d;
    logic [width_p-1:0]       head_data_q, head_data_d, skid_data_q, skid_data_d;

    logic       enq, deq, rd_issue;
    logic [1:0] obuf_cnt_next;

    // ready_o looks only at committed RAM occupancy, never at this cycle's read issue.
    assign ready_o       = (ram_cnt_q < els_cnt_lp);
    assign enq           = v_i & ready_o;
    assign deq           = yumi_i & head_v_q;
    assign obuf_cnt_next = 2'(head_v_q) + 2'(skid_v_q) - 2'(deq);
    assign rd_issue      = (ram_cnt_q != '0) && ((obuf_cnt_next + 2'(rd_inflight_q)) < 2'd2);

    assign mem_w_v_o    = enq;
    assign mem_w_addr_o = wptr_q;
    assign mem_w_data_o = data_i;
    assign mem_r_v_o    = rd_issue;
    assign mem_r_addr_o = rptr_q;
    assign v_o          = head_v_q;
    assign data_o       = head_data_q;
    assign count_o      = count_q;

    always_comb begin
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        ram_cnt_d     = ram_cnt_q + cnt_width_lp'(enq) - cnt_width_lp'(rd_issue);
        count_d       = count_q + cnt_width_lp'(enq) - cnt_width_lp'(deq);
        rd_inflight_d = rd_issue;
        head_v_d      = head_v_q;
        skid_v_d      = skid_v_q;
        head_data_d   = head_data_q;
        skid_data_d   = skid_data_q;

        if (enq) wptr_d = (wptr_q == last_ptr_lp) ? '0 : wptr_q + addr_width_lp'(1);
        if (rd_issue) rptr_d = (rptr_q == last_ptr_lp) ? '0 : rptr_q + addr_width_lp'(1);

        // Pop first, then land returning RAM data in the first free slot so order is kept.
        if (deq) begin
            head_v_d    = skid_v_q;
            head_data_d = skid_data_q;
            skid_v_d    = 1'b0;
        end
        if (rd_inflight_q) begin
            if (!head_v_d) begin
                head_v_d    = 1'b1;
                head_data_d = mem_r_data_i;
            end else begin
                skid_v_d    = 1'b1;
                skid_data_d = mem_r_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            ram_cnt_q     <= '0;
            count_q       <= '0;
            rd_inflight_q <= 1'b0;
            head_v_q      <= 1'b0;
            skid_v_q      <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            ram_cnt_q     <= ram_cnt_d;
            count_q       <= count_d;
            rd_inflight_q <= rd_inflight_d;
            head_v_q      <= head_v_d;
            skid_v_q      <= skid_v_d;
        end
    end

    always_ff @(posedge clk_i) begin
        head_data_q <= head_data_d;
        skid_data_q <= skid_data_d;
    end

`ifdef BSG_MEM_1R1W_SYNC_FIFO_CTRL_CHECK_EN
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !head_v_q))
                else $error("%m: yumi_i asserted while v_o=0");
            assert (ram_cnt_q <= els_cnt_lp)
                else $error("%m: ram_cnt %0d exceeds els_p", ram_cnt_q);
            assert (count_q == ram_cnt_q + cnt_width_lp'(rd_inflight_q)
                               + cnt_width_lp'(head_v_q) + cnt_width_lp'(skid_v_q))
                else $error("%m: count_o %0d inconsistent with internal occupancy", count_q);
            assert ((wptr_q <= last_ptr_lp) && (rptr_q <= last_ptr_lp))
                else $error("%m: pointer out of range w=%0d r=%0d", wptr_q, rptr_q);
        end
    end
`else
`endif

endmodule

// File: tb/tb_bsg_mem_1r1w_sync_fifo_ctrl.sv
// Bench for bsg_mem_1r1w_sync_fifo_ctrl: two instances (els_p=4 and els_p=3), each with a RAM model,
// checked against a queue-based reference of the FIFO contents.
module tb_bsg_mem_1r1w_sync_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       v_i[2], ready_o[2], v_o[2], yumi_i[2], mwv[2], mrv[2];
    logic [7:0] data_i[2], data_o[2], mwd[2], mrd[2];
    logic [2:0] count_o[2];
    logic [1:0] mwa[2], mra[2];
    logic [7:0] mem[2][4];

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bsg_mem_1r1w_sync_fifo_ctrl #(.width_p(8), .els_p(4)) u_dut4 (
        .clk_i(clk), .reset_i(rst), .v_i(v_i[0]), .data_i(data_i[0]), .ready_o(ready_o[0]),
        .v_o(v_o[0]), .data_o(data_o[0]), .yumi_i(yumi_i[0]), .count_o(count_o[0]),
        .mem_w_v_o(mwv[0]), .mem_w_addr_o(mwa[0]), .mem_w_data_o(mwd[0]),
        .mem_r_v_o(mrv[0]), .mem_r_addr_o(mra[0]), .mem_r_data_i(mrd[0])
    );

    bsg_mem_1r1w_sync_fifo_ctrl #(.width_p(8), .els_p(3)) u_dut3 (
        .clk_i(clk), .reset_i(rst), .v_i(v_i[1]), .data_i(data_i[1]), .ready_o(ready_o[1]),
        .v_o(v_o[1]), .data_o(data_o[1]), .yumi_i(yumi_i[1]), .count_o(count_o[1]),
        .mem_w_v_o(mwv[1]), .mem_w_addr_o(mwa[1]), .mem_w_data_o(mwd[1]),
        .mem_r_v_o(mrv[1]), .mem_r_addr_o(mra[1]), .mem_r_data_i(mrd[1])
    );

    // Synchronous-read RAM next to each controller.
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (mwv[u]) mem[u][mwa[u]] <= mwd[u];
            if (mrv[u]) mrd[u] <= mem[u][mra[u]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        for (int u = 0; u < 2; u++) begin
            v_i[u] = 1'b0; yumi_i[u] = 1'b0; data_i[u] = '0;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_random(input int u, input int els, input int ncyc);
        logic [7:0] q[$];
        logic [7:0] d;
        logic       vv, yy;
        do_reset();
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            chk("rnd_count", count_o[u], q.size());
            if (q.size() < els) chk("rnd_ready_hi", ready_o[u], 1);
            if (q.size() == els + 2) chk("rnd_ready_full", ready_o[u], 0);
            if (q.size() == 0) chk("rnd_v_empty", v_o[u], 0);
            vv = 1'($urandom_range(0, 1));
            yy = v_o[u] & 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            v_i[u] = vv; data_i[u] = d; yumi_i[u] = yy;
            if (yy) begin
                if (q.size() == 0) chk("rnd_underflow", 1, 0);
                else chk("rnd_data", data_o[u], q.pop_front());
            end
            if (vv && ready_o[u]) q.push_back(d);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, got, sent, gaps, addr_bad, bound;
        logic started;
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_ready", ready_o[u], 1);
            chk("rst_v", v_o[u], 0);
            chk("rst_count", count_o[u], 0);
            chk("rst_mem_r_v", mrv[u], 0);
        end

        // Single word: visible in the third cycle counting from the enqueue cycle.
        do_reset();
        @(negedge clk);
        v_i[0] = 1'b1; data_i[0] = 8'hA5;
        @(negedge clk);
        v_i[0] = 1'b0;
        chk("lat_count", count_o[0], 1);
        chk("lat_v_c1", v_o[0], 0);
        @(negedge clk);
        chk("lat_v_c2", v_o[0], 0);
        @(negedge clk);
        chk("lat_v_c3", v_o[0], 1);
        chk("lat_data", data_o[0], 8'hA5);
        yumi_i[0] = 1'b1;
        @(negedge clk);
        yumi_i[0] = 1'b0;
        chk("lat_v_after_pop", v_o[0], 0);
        chk("lat_count_after_pop", count_o[0], 0);

        // Fill to capacity els_p+2 with no dequeue, then drain in order.
        do_reset();
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            v_i[0] = 1'b1; data_i[0] = 8'(acc);
            if (ready_o[0]) acc++;
        end
        @(negedge clk);
        v_i[0] = 1'b0;
        chk("fill_accepts", acc, 6);
        chk("fill_ready", ready_o[0], 0);
        chk("fill_count", count_o[0], 6);
        got = 0;
        for (int i = 0; i < 40 && got < 6; i++) begin
            @(negedge clk);
            if (v_o[0]) begin
                chk("fill_data", data_o[0], got);
                got++;
                yumi_i[0] = 1'b1;
            end else yumi_i[0] = 1'b0;
        end
        @(negedge clk);
        yumi_i[0] = 1'b0;
        chk("fill_drained", got, 6);
        chk("fill_count_end", count_o[0], 0);

        // Streaming through the els_p=3 instance: no gaps once output starts.
        do_reset();
        got = 0; sent = 0; gaps = 0; addr_bad = 0; started = 1'b0;
        for (int i = 0; i < 400 && got < 100; i++) begin
            @(negedge clk);
            if (mwv[1] && mwa[1] > 2'd2) addr_bad++;
            if (mrv[1] && mra[1] > 2'd2) addr_bad++;
            if (v_o[1]) begin
                chk("str_data", data_o[1], got);
                got++;
                started = 1'b1;
                yumi_i[1] = 1'b1;
            end else begin
                yumi_i[1] = 1'b0;
                if (started) gaps++;
            end
            v_i[1] = (sent < 100); data_i[1] = 8'(sent);
            if (sent < 100 && ready_o[1]) sent++;
        end
        @(negedge clk);
        idle_inputs();
        chk("str_got", got, 100);
        chk("str_gaps", gaps, 0);
        chk("str_addr_range", addr_bad, 0);
        chk("str_count_end", count_o[1], 0);

        run_random(0, 4, 10000);
        run_random(1, 3, 3000);

        // Asynchronous reset while a read is in flight and the head holds data.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            v_i[0] = 1'b1; data_i[0] = 8'(8'h11 + i);
        end
        @(negedge clk);
        v_i[0] = 1'b0;
        chk("mid_v_before", v_o[0], 1);
        chk("mid_count_before", count_o[0], 3);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_v_async", v_o[0], 0);
        chk("mid_count_async", count_o[0], 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_v_settled", v_o[0], 0);
        chk("mid_count_settled", count_o[0], 0);
        v_i[0] = 1'b1; data_i[0] = 8'h3C;
        @(negedge clk);
        v_i[0] = 1'b0;
        bound = 0;
        while (!v_o[0] && bound < 10) begin
            @(negedge clk);
            bound++;
        end
        chk("mid_v_timeout", v_o[0], 1);
        chk("mid_first_data", data_o[0], 8'h3C);
        yumi_i[0] = v_o[0];
        @(negedge clk);
        yumi_i[0] = 1'b0;
        chk("mid_count_end", count_o[0], 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/bsg_mem_1r1w_sync_fifo_ctrl.md
Name: bsg_mem_1r1w_sync_fifo_ctrl

Overview:
Controller that sequences an external 1-read/1-write synchronous-read RAM as a FIFO. It owns the read/write pointers and the occupancy count, and drives the RAM write/read ports. It hides the RAM's 1-cycle read latency behind a 2-entry output buffer, so the consumer sees a valid/yumi interface at full throughput. It sits between a producer (valid/ready) and a consumer (valid/yumi), next to a bsg_mem_1r1w_sync instance.

Parameters:
width_p, (none, must be set), data width in bits; >=1.
els_p, (none, must be set), RAM depth; >=2, any value, need not be a power of 2.
addr_width_lp, `BSG_SAFE_CLOG2(els_p), RAM address width.
cnt_width_lp, `BSG_SAFE_CLOG2(els_p+3), width of the total-occupancy count.

Ports:
clk_i  in  1  clock; all state updates on posedge.
reset_i  in  1  asynchronous reset, active-high.
v_i  in  1  producer data valid.
data_i  in  width_p  producer data.
ready_o  out  1  controller can accept; v_i&ready_o = enqueue.
v_o  out  1  head of FIFO valid.
data_o  out  width_p  head data.
yumi_i  in  1  consumer takes head; legal only when v_o=1.
count_o  out  cnt_width_lp  total entries: RAM + in-flight + output buffer.
mem_w_v_o  out  1  RAM write enable.
mem_w_addr_o  out  addr_width_lp  RAM write address.
mem_w_data_o  out  width_p  RAM write data.
mem_r_v_o  out  1  RAM read enable.
mem_r_addr_o  out  addr_width_lp  RAM read address.
mem_r_data_i  in  width_p  RAM read data, valid the cycle after mem_r_v_o.

Behaviour:
- Reset is asynchronous, active-high. It clears wptr, rptr, ram_cnt, rd_inflight_r, both buffer valids and count_o to 0. After reset: ready_o=1, v_o=0. data_o is don't-care while v_o=0.
- Enqueue: mem_w_v_o = v_i & ready_o; mem_w_addr_o=wptr; mem_w_data_o=data_i (combinational). ready_o = (ram_cnt < els_p). wptr increments and wraps from els_p-1 to 0.
- Read issue: mem_r_v_o = (ram_cnt!=0) & (obuf_cnt_next + rd_inflight_r < 2).
  - obuf_cnt_next = obuf_cnt - yumi_i.
  - mem_r_addr_o = rptr; rptr increments with the same wrap rule.
  - rd_inflight_r <= mem_r_v_o.
- No same-address read/write: ram_cnt counts only writes already committed, so a read never targets the address being written that cycle. Write-to-v_o latency is therefore 3 cycles (write, read issue, capture). No combinational path from v_i to v_o.
- Capture: when rd_inflight_r=1, mem_r_data_i is written into the output buffer, after this cycle's pop.
- Output buffer: head/skid, strictly in order. yumi pops head; skid moves to head. Capture goes to head if head is empty after the pop, else to skid. Simultaneous pop and capture with obuf_cnt=1 yields obuf_cnt=1 holding the new data.
- ram_cnt update: ram_cnt <= ram_cnt + enq - mem_r_v_o.
- count_o update: count_o <= count_o + enq - (yumi_i & v_o).
- Full: ram_cnt=els_p, so ready_o=0. Total capacity is els_p+2.
- Empty: v_o=0 until data arrives; mem_r_v_o=0.
- Throughput: sustains 1 enq + 1 deq per cycle indefinitely once v_o=1.
- Simultaneous enq on a full RAM with a same-cycle read issue: still refused. ready_o depends only on registered ram_cnt.
- Reset mid-operation discards all contents, including an in-flight read. The returned data is ignored because rd_inflight_r is cleared.
- yumi_i while v_o=0 is illegal; behaviour undefined (caught by the optional checker).

Optional Feature:
Macro BSG_MEM_1R1W_SYNC_FIFO_CTRL_CHECK_EN.
- Defined: simulation-only assertions, sampled at posedge outside reset, each printing $error with %m.
  - yumi_i & ~v_o
  - ram_cnt > els_p
  - count_o != ram_cnt + rd_inflight_r + obuf_cnt
  - pointer >= els_p
- Undefined: no checker logic or messages. Functional RTL identical in both cases.

Test Plan:
- Reset, then v_i=1 with data 0xA5 for one cycle (els_p=4, width_p=8) -> v_o=1 with data_o=0xA5 exactly 3 cycles after the enqueue edge; count_o=1.
- Enqueue 0..5 with yumi_i=0 (els_p=4) -> ready_o drops after 6 accepts; count_o=6; dequeuing yields 0,1,2,3,4,5 in order.
- Continuous enq and deq of an incrementing stream, 100 words, els_p=3 -> one word per cycle after fill; no gaps or duplicates; pointers wrap cleanly at 3.
- Random v_i and yumi_i (50%), 10k cycles -> data order matches a scoreboard; count_o always equals the model; ready_o=0 only when count_o >= els_p.
- Assert reset_i asynchronously mid-stream with a read in flight -> v_o=0, count_o=0 immediately. Next enqueue 0x3C is the first dequeued word.
- With CHECK_EN defined, pulse yumi_i while v_o=0 -> exactly one $error reported.
